// File: rtl/linear_system_checker.sv
// Loads a user-entered 2x2 linear system one coefficient at a time, solves it
// by elimination on one shared multiplier, then grades the player's x/y answers.

module linear_system_checker #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         start,
    input  logic         Go,
    input  logic [W-1:0] data_in,
    output logic         busy,
    output logic         ready_ans,
    output logic [2:0]   entry_idx,
    output logic [W-1:0] sol_x,
    output logic [W-1:0] sol_y,
    output logic         correct,
    output logic         wrong,
    output logic         unsolvable
);

    localparam int AW = 2*W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_D1, S_D2, S_X1, S_X2, S_Y1, S_Y2,
        S_DIV, S_ANS, S_CHK, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic go_q;
    logic [2:0] idx_q, idx_d;
    logic signed [W-1:0] coef_q [6];
    logic signed [W-1:0] coef_d [6];
    logic [W-1:0] ansX_q, ansX_d, ansY_q, ansY_d;
    logic signed [AW-1:0] det_q, det_d, numX_q, numX_d, numY_q, numY_d;
    logic [W-1:0] solX_q, solX_d, solY_q, solY_d;
    logic busy_q, busy_d, ready_q, ready_d;
    logic correct_q, correct_d, wrong_q, wrong_d, unsolv_q, unsolv_d;

    logic accept;
    logic signed [W-1:0] mulA, mulB;
    logic signed [2*W-1:0] product;
    logic signed [AW-1:0] productExt;
    logic signed [AW-1:0] divisor, quotX, quotY, remX, remY;
    logic solvable;

    // A quotient is usable only if it sign-extends cleanly from W bits.
    function automatic logic fitsW(input logic signed [AW-1:0] v);
        return v[AW-1:W-1] == {(AW-W+1){v[W-1]}};
    endfunction

    assign accept = Go && !go_q && (state_q == S_LOAD || state_q == S_ANS);

    // Coefficient order in coef_q is a1, b1, c1, a2, b2, c2.
    always_comb begin
        mulA = '0;
        mulB = '0;
        case (state_q)
            S_D1:    begin mulA = coef_q[0]; mulB = coef_q[4]; end
            S_D2:    begin mulA = coef_q[3]; mulB = coef_q[1]; end
            S_X1:    begin mulA = coef_q[2]; mulB = coef_q[4]; end
            S_X2:    begin mulA = coef_q[5]; mulB = coef_q[1]; end
            S_Y1:    begin mulA = coef_q[0]; mulB = coef_q[5]; end
            S_Y2:    begin mulA = coef_q[3]; mulB = coef_q[2]; end
            default: begin mulA = '0;        mulB = '0;        end
        endcase
    end

    assign product    = (2*W)'(mulA) * (2*W)'(mulB);
    assign productExt = AW'(product);

    // Divisor is forced to 1 when the determinant is zero so the divider never sees 0.
    assign divisor  = (det_q == '0) ? AW'(1) : det_q;
    assign quotX    = numX_q / divisor;
    assign remX     = numX_q % divisor;
    assign quotY    = numY_q / divisor;
    assign remY     = numY_q % divisor;
    assign solvable = (det_q != '0) && (remX == '0) && (remY == '0)
                      && fitsW(quotX) && fitsW(quotY);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        coef_d    = coef_q;
        ansX_d    = ansX_q;
        ansY_d    = ansY_q;
        det_d     = det_q;
        numX_d    = numX_q;
        numY_d    = numY_q;
        solX_d    = solX_q;
        solY_d    = solY_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        unsolv_d  = unsolv_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    coef_d[idx_q] = data_in;
                    if (idx_q == 3'd5) begin
                        idx_d   = '0;
                        state_d = S_D1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_D1: begin det_d  = productExt;          state_d = S_D2; end
            S_D2: begin det_d  = det_q - productExt;  state_d = S_X1; end
            S_X1: begin numX_d = productExt;          state_d = S_X2; end
            S_X2: begin numX_d = numX_q - productExt; state_d = S_Y1; end
            S_Y1: begin numY_d = productExt;          state_d = S_Y2; end
            S_Y2: begin numY_d = numY_q - productExt; state_d = S_DIV; end
            S_DIV: begin
                idx_d = '0;
                if (solvable) begin
                    solX_d  = quotX[W-1:0];
                    solY_d  = quotY[W-1:0];
                    state_d = S_ANS;
                end else begin
                    solX_d   = '0;
                    solY_d   = '0;
                    unsolv_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_ANS: begin
                if (accept) begin
                    if (idx_q == 3'd0) begin
                        ansX_d = data_in;
                        idx_d  = 3'd1;
                    end else begin
                        ansY_d  = data_in;
                        idx_d   = '0;
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (ansX_q == solX_q && ansY_q == solY_q) begin
                    correct_d = 1'b1;
                end else begin
                    wrong_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    unsolv_d  = 1'b0;
                    idx_d     = '0;
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = state_d inside {S_D1, S_D2, S_X1, S_X2, S_Y1, S_Y2, S_DIV};
        ready_d = (state_d == S_ANS);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            go_q      <= 1'b0;
            idx_q     <= '0;
            for (int i = 0; i < 6; i++) begin
                coef_q[i] <= '0;
            end
            ansX_q    <= '0;
            ansY_q    <= '0;
            det_q     <= '0;
            numX_q    <= '0;
            numY_q    <= '0;
            solX_q    <= '0;
            solY_q    <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            unsolv_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= Go;
            idx_q     <= idx_d;
            coef_q    <= coef_d;
            ansX_q    <= ansX_d;
            ansY_q    <= ansY_d;
            det_q     <= det_d;
            numX_q    <= numX_d;
            numY_q    <= numY_d;
            solX_q    <= solX_d;
            solY_q    <= solY_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            unsolv_q  <= unsolv_d;
        end
    end

    assign busy       = busy_q;
    assign ready_ans  = ready_q;
    assign entry_idx  = idx_q;
    assign sol_x      = solX_q;
    assign sol_y      = solY_q;
    assign correct    = correct_q;
    assign wrong      = wrong_q;
    assign unsolvable = unsolv_q;

endmodule

// File: tb/tb_linear_system_checker.sv
// Bench for linear_system_checker: fixed problem table plus random systems graded
// against a Cramer's-rule reference model, and hand-written Go/reset sequences.

module tb_linear_system_checker;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         start;
    logic         Go;
    logic [W-1:0] data_in;
    logic         busy;
    logic         ready_ans;
    logic [2:0]   entry_idx;
    logic [W-1:0] sol_x;
    logic [W-1:0] sol_y;
    logic         correct;
    logic         wrong;
    logic         unsolvable;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [5:0][7:0] coef;
        int ax;
        int ay;
        bit expU;
        int ex;
        int ey;
        bit expC;
    } vec_t;

    vec_t vecs[$];

    linear_system_checker #(.W(W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .Go         (Go),
        .data_in    (data_in),
        .busy       (busy),
        .ready_ans  (ready_ans),
        .entry_idx  (entry_idx),
        .sol_x      (sol_x),
        .sol_y      (sol_y),
        .correct    (correct),
        .wrong      (wrong),
        .unsolvable (unsolvable)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] time limit exceeded");
    end

    function automatic int s8(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: Cramer's rule in plain integer arithmetic.
    task automatic modelSolve(inout vec_t v);
        int a1, b1, c1, a2, b2, c2, d, nx, ny;
        a1 = s8(v.coef[0]); b1 = s8(v.coef[1]); c1 = s8(v.coef[2]);
        a2 = s8(v.coef[3]); b2 = s8(v.coef[4]); c2 = s8(v.coef[5]);
        d  = a1*b2 - a2*b1;
        nx = c1*b2 - c2*b1;
        ny = a1*c2 - a2*c1;
        v.ex = 0;
        v.ey = 0;
        if (d == 0 || (nx % d) != 0 || (ny % d) != 0) begin
            v.expU = 1'b1;
        end else begin
            v.ex   = nx / d;
            v.ey   = ny / d;
            v.expU = (v.ex < -128 || v.ex > 127 || v.ey < -128 || v.ey > 127);
        end
    endtask

    task automatic addVec(input int a1, b1, c1, a2, b2, c2, ax, ay,
                          input bit u, input int ex, ey, input bit c);
        vec_t v;
        v.coef[0] = a1[7:0]; v.coef[1] = b1[7:0]; v.coef[2] = c1[7:0];
        v.coef[3] = a2[7:0]; v.coef[4] = b2[7:0]; v.coef[5] = c2[7:0];
        v.ax = ax; v.ay = ay; v.expU = u; v.ex = ex; v.ey = ey; v.expC = c;
        vecs.push_back(v);
    endtask

    task automatic pressGo(input logic [7:0] v);
        @(negedge Clock);
        data_in = v;
        Go      = 1'b1;
        @(negedge Clock);
        Go      = 1'b0;
    endtask

    task automatic startProblem();
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        checkOutput("start_entry_idx", entry_idx, 0);
        checkOutput("start_flags_clear", {correct, wrong, unsolvable}, 0);
        checkOutput("start_busy", busy, 0);
    endtask

    // Loads coefficients from fromIdx onward, checks compute timing and grading.
    task automatic applyStimulus(input vec_t v, input int fromIdx, input bit toggleBusy);
        for (int i = fromIdx; i < 6; i++) begin
            pressGo(v.coef[i]);
            if (i < 5) checkOutput("load_entry_idx", entry_idx, i + 1);
        end
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge Clock);
            checkOutput("busy_window", busy, 1);
            if (toggleBusy) Go = ((k % 2) == 1);
        end
        @(negedge Clock);
        Go = 1'b0;
        checkOutput("busy_after_div", busy, 0);
        checkOutput("unsolvable_at_T8", unsolvable, int'(v.expU));
        checkOutput("ready_ans_at_T8", ready_ans, int'(!v.expU));
        if (v.expU) begin
            repeat (3) @(negedge Clock);
            checkOutput("ready_ans_stays_low", ready_ans, 0);
            checkOutput("unsolvable_exclusive", {correct, wrong, unsolvable}, 3'b001);
        end else begin
            checkOutput("sol_x", s8(sol_x), v.ex);
            checkOutput("sol_y", s8(sol_y), v.ey);
            checkOutput("ans_entry_idx0", entry_idx, 0);
            pressGo(v.ax[7:0]);
            checkOutput("ans_entry_idx1", entry_idx, 1);
            pressGo(v.ay[7:0]);
            checkOutput("chk_no_flags", {correct, wrong, unsolvable}, 0);
            @(negedge Clock);
            checkOutput("correct", correct, int'(v.expC));
            checkOutput("wrong", wrong, int'(!v.expC));
            checkOutput("unsolvable_after_chk", unsolvable, 0);
        end
    endtask

    initial begin
        vec_t v;
        int x, y;

        // Fixed table: the documented scenarios plus quotient boundaries.
        addVec(2, 2, 10, 1, 4, 8,        4, 1,       0, 4, 1,       1);
        addVec(2, 2, 10, 1, 4, 8,        4, 2,       0, 4, 1,       0);
        addVec(1, 2, 3, 2, 4, 6,         0, 0,       1, 0, 0,       0);
        addVec(1, 1, 1, 1, -1, 0,        0, 0,       1, 0, 0,       0);
        addVec(1, 1, -1, 1, -1, 3,       1, -2,      0, 1, -2,      1);
        addVec(-1, 0, -128, 0, 1, 0,     0, 0,       1, 0, 0,       0);
        addVec(1, 1, -1, 1, -1, 3,       1, -1,      0, 1, -2,      0);
        addVec(1, 0, -128, 0, 1, 5,      -128, 5,    0, -128, 5,    1);
        addVec(1, 0, 127, 0, 1, -128,    127, -128,  0, 127, -128,  1);

        // Random systems: even ones built from a known small solution, odd ones arbitrary.
        for (int n = 0; n < 30; n++) begin
            if (n % 2 == 0) begin
                x = int'($urandom_range(0, 20)) - 10;
                y = int'($urandom_range(0, 20)) - 10;
                for (int r = 0; r < 2; r++) begin
                    int a, b, c;
                    a = int'($urandom_range(0, 16)) - 8;
                    b = int'($urandom_range(0, 16)) - 8;
                    c = a*x + b*y;
                    v.coef[3*r]     = a[7:0];
                    v.coef[3*r + 1] = b[7:0];
                    v.coef[3*r + 2] = c[7:0];
                end
            end else begin
                for (int k = 0; k < 6; k++) v.coef[k] = 8'($urandom_range(0, 255));
            end
            modelSolve(v);
            v.ax = v.ex;
            v.ay = v.ey;
            if ($urandom_range(0, 2) == 0) v.ay = v.ey + int'($urandom_range(1, 6));
            v.expC = !v.expU && (s8(v.ax[7:0]) == v.ex) && (s8(v.ay[7:0]) == v.ey);
            vecs.push_back(v);
        end

        Reset   = 1'b1;
        start   = 1'b0;
        Go      = 1'b0;
        data_in = '0;
        repeat (2) @(negedge Clock);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready_ans", ready_ans, 0);
        checkOutput("reset_entry_idx", entry_idx, 0);
        checkOutput("reset_flags", {correct, wrong, unsolvable}, 0);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            startProblem();
            applyStimulus(vecs[i], 0, (i % 2) == 1);
        end

        // start and Go together in IDLE: the Go edge must be dropped.
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        start   = 1'b1;
        Go      = 1'b1;
        data_in = 8'd99;
        @(negedge Clock);
        start = 1'b0;
        Go    = 1'b0;
        checkOutput("idle_go_ignored_idx", entry_idx, 0);
        applyStimulus(vecs[0], 0, 1'b0);

        // Go held for ten cycles in LOAD counts once.
        startProblem();
        @(negedge Clock);
        data_in = vecs[0].coef[0];
        Go      = 1'b1;
        repeat (10) @(negedge Clock);
        Go = 1'b0;
        checkOutput("held_go_single_entry", entry_idx, 1);
        applyStimulus(vecs[0], 1, 1'b0);

        // Reset while in X1 returns everything to zero, then a clean rerun works.
        startProblem();
        for (int i = 0; i < 6; i++) pressGo(vecs[0].coef[i]);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_ready_ans", ready_ans, 0);
        checkOutput("midreset_entry_idx", entry_idx, 0);
        checkOutput("midreset_sol", {sol_x, sol_y}, 0);
        checkOutput("midreset_flags", {correct, wrong, unsolvable}, 0);
        Reset = 1'b0;
        startProblem();
        applyStimulus(vecs[0], 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
